// File: rtl/vend_pkg.sv
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared constants and types for the vending controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam int unsigned c_DEBOUNCE_DEFAULT = 16;
    localparam int unsigned c_DEBOUNCE_MIN     = 4;
    localparam int unsigned c_DEBOUNCE_MAX     = 65535;

    // Credit counter width used by the downstream credit/dispense FSM.
    localparam int unsigned c_CREDIT_W         = 8;

    typedef struct packed {
        logic m;
        logic a;
    } req_t;

endpackage

`default_nettype wire

// File: rtl/vend_debounce.sv
// ============================================================================
//  Module      : vend_debounce
//  Description : Two-flop synchronizer, counting debouncer and rise detector.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vend_debounce
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = db_q & ~db_dly_q;

endmodule

`default_nettype wire

// File: rtl/vend_input_conditioner.sv
// ============================================================================
//  Module      : vend_input_conditioner
//  Description : Debounces coin/select inputs and arbitrates them into
//                mutually exclusive single-cycle m/a request pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vend_input_conditioner
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_raw,
    input  logic sel_raw,
    output logic m,
    output logic a,
    output logic coin_db,
    output logic sel_db
);

    generate
        if (DEBOUNCE_CYCLES < c_DEBOUNCE_MIN || DEBOUNCE_CYCLES > c_DEBOUNCE_MAX) begin : g_bad_debounce
            $error("vend_input_conditioner: DEBOUNCE_CYCLES out of range 4..65535");
        end
    endgenerate

    logic w_coin_rise;
    logic w_sel_rise;
    logic pend_m_q;
    logic pend_m_d;
    logic pend_a_q;
    logic pend_a_d;
    req_t out_q;
    req_t out_d;

    vend_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_coin_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (coin_raw),
        .db_o   (coin_db),
        .rise_o (w_coin_rise)
    );

    vend_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sel_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (sel_raw),
        .db_o   (sel_db),
        .rise_o (w_sel_rise)
    );

    // Coin has fixed priority; a new rise overrides a same-cycle clear.
    always_comb begin
        out_d.m  = pend_m_q;
        out_d.a  = pend_a_q & ~pend_m_q;
        pend_m_d = w_coin_rise;
        pend_a_d = w_sel_rise | (pend_a_q & pend_m_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_m_q <= 1'b0;
            pend_a_q <= 1'b0;
            out_q    <= '0;
        end else begin
            pend_m_q <= pend_m_d;
            pend_a_q <= pend_a_d;
            out_q    <= out_d;
        end
    end

    assign m = out_q.m;
    assign a = out_q.a;

endmodule

`default_nettype wire

// File: tb/tb_vend_input_conditioner.sv
// ============================================================================
//  Module      : tb_vend_input_conditioner
//  Description : Directed self-checking bench for vend_input_conditioner, N=4.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vend_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic coin_raw;
    logic sel_raw;
    logic m;
    logic a;
    logic coin_db;
    logic sel_db;

    int tests  = 0;
    int fails  = 0;
    int cnt_m  = 0;
    int cnt_a  = 0;

    vend_input_conditioner #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .coin_raw (coin_raw),
        .sel_raw  (sel_raw),
        .m        (m),
        .a        (a),
        .coin_db  (coin_db),
        .sel_db   (sel_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting pulses and checking exclusivity each cycle.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cnt_m += int'(m);
            cnt_a += int'(a);
            chk("m_a_exclusive", m & a, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        coin_raw = 1'b0;
        sel_raw  = 1'b0;
        #1;
        chk("rst_m", m, 1'b0);
        chk("rst_a", a, 1'b0);
        chk("rst_coin_db", coin_db, 1'b0);
        chk("rst_sel_db", sel_db, 1'b0);
        step(); step(); step();
        reset = 1'b0;
        step();

        // Scenario 1: clean coin press
        coin_raw = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            step();
            chk("t1_m", m, e == 7);
            chk("t1_coin_db", coin_db, e >= 5);
            chk("t1_a", a, 1'b0);
        end
        coin_raw = 1'b0;
        cnt_m = 0; cnt_a = 0;
        watch(12);
        chk_int("t1_release_m_count", cnt_m, 0);
        chk("t1_release_coin_db", coin_db, 1'b0);

        // Scenario 2: bounce rejection then a real press
        coin_raw = 1'b1; step();
        coin_raw = 1'b0; step();
        coin_raw = 1'b1; step();
        coin_raw = 1'b1; step();
        coin_raw = 1'b0; step();
        for (int e = 0; e < 12; e++) begin
            step();
            chk("t2_bounce_m", m, 1'b0);
            chk("t2_bounce_coin_db", coin_db, 1'b0);
        end
        coin_raw = 1'b1;
        cnt_m = 0; cnt_a = 0;
        watch(10);
        coin_raw = 1'b0;
        watch(12);
        chk_int("t2_m_count", cnt_m, 1);
        chk_int("t2_a_count", cnt_a, 0);
        chk("t2_coin_db_low", coin_db, 1'b0);

        // Scenario 3: simultaneous rise
        coin_raw = 1'b1;
        sel_raw  = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            step();
            chk("t3_m", m, e == 7);
            chk("t3_a", a, e == 8);
            chk("t3_exclusive", m & a, 1'b0);
            chk("t3_sel_db", sel_db, e >= 5);
        end
        coin_raw = 1'b0;
        sel_raw  = 1'b0;
        watch(12);

        // Scenario 4: held select, release, press again
        sel_raw = 1'b1;
        cnt_m = 0; cnt_a = 0;
        watch(50);
        chk_int("t4_first_a_count", cnt_a, 1);
        chk_int("t4_m_count", cnt_m, 0);
        chk("t4_sel_db_high", sel_db, 1'b1);
        sel_raw = 1'b0;
        watch(10);
        chk("t4_sel_db_low", sel_db, 1'b0);
        sel_raw = 1'b1;
        cnt_a = 0;
        watch(20);
        chk_int("t4_second_a_count", cnt_a, 1);
        sel_raw = 1'b0;
        watch(12);

        // Scenario 5: reset mid-debounce, then a normal press
        coin_raw = 1'b1;
        step(); step(); step();
        reset    = 1'b1;
        coin_raw = 1'b0;
        #1;
        chk("t5_rst_m", m, 1'b0);
        chk("t5_rst_coin_db", coin_db, 1'b0);
        step();
        chk("t5_rst_hold_m", m, 1'b0);
        chk("t5_rst_hold_a", a, 1'b0);
        reset = 1'b0;
        cnt_m = 0; cnt_a = 0;
        watch(15);
        chk_int("t5_no_pulse", cnt_m, 0);
        coin_raw = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            step();
            chk("t5_m", m, e == 7);
            chk("t5_coin_db", coin_db, e >= 5);
        end
        coin_raw = 1'b0;
        watch(12);

        // Reset while a request is pending must drop it
        coin_raw = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
        end
        chk("t5b_pre_m", m, 1'b0);
        reset    = 1'b1;
        coin_raw = 1'b0;
        #1;
        chk("t5b_rst_coin_db", coin_db, 1'b0);
        step();
        reset = 1'b0;
        cnt_m = 0; cnt_a = 0;
        watch(10);
        chk_int("t5b_dropped", cnt_m, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
